// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - 640x480@60Hz pixel timing generator with delayed sync outputs
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_DLY = 1
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       blank,
    output logic       hs,
    output logic       vs,
    output logic       vblank_start,
    output logic       frame_end,
    output logic [7:0] frame_count
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [9:0] hc_q, hc_d;
    logic [9:0] vc_q, vc_d;
    logic [7:0] frame_q, frame_d;
    logic       h_wrap, v_wrap;
    logic       hs_raw, vs_raw;

    always_comb begin
        h_wrap  = (hc_q == H_LAST);
        v_wrap  = (vc_q == V_LAST);
        hc_d    = h_wrap ? 10'd0 : hc_q + 10'd1;
        vc_d    = vc_q;
        frame_d = frame_q;
        if (h_wrap) begin
            if (v_wrap) begin
                vc_d    = 10'd0;
                frame_d = frame_q + 8'd1;
            end else begin
                vc_d = vc_q + 10'd1;
            end
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            hc_q    <= 10'd0;
            vc_q    <= 10'd0;
            frame_q <= 8'd0;
        end else begin
            hc_q    <= hc_d;
            vc_q    <= vc_d;
            frame_q <= frame_d;
        end
    end

    // vc only moves on the hc wrap, so vsync naturally spans whole lines
    assign hs_raw = !((hc_q >= HS_FIRST) && (hc_q <= HS_LAST));
    assign vs_raw = !((vc_q >= VS_FIRST) && (vc_q <= VS_LAST));

    assign DrawX        = hc_q;
    assign DrawY        = vc_q;
    assign frame_count  = frame_q;
    assign blank        = (hc_q < H_VIS) && (vc_q < V_VIS);
    assign vblank_start = (hc_q == 10'd0) && (vc_q == V_VIS);
    assign frame_end    = h_wrap && v_wrap;

    generate
        if (SYNC_DLY == 0) begin : g_no_dly
            assign hs = hs_raw;
            assign vs = vs_raw;
        end else begin : g_dly
            logic [SYNC_DLY-1:0] hs_pipe_q;
            logic [SYNC_DLY-1:0] vs_pipe_q;

            // Stages idle high so reset release never emits a stray sync pulse
            always_ff @(posedge vga_clk or negedge reset_n) begin
                if (!reset_n) begin
                    hs_pipe_q <= '1;
                    vs_pipe_q <= '1;
                end else begin
                    hs_pipe_q[0] <= hs_raw;
                    vs_pipe_q[0] <= vs_raw;
                    for (int i = 1; i < SYNC_DLY; i++) begin
                        hs_pipe_q[i] <= hs_pipe_q[i-1];
                        vs_pipe_q[i] <= vs_pipe_q[i-1];
                    end
                end
            end

            assign hs = hs_pipe_q[SYNC_DLY-1];
            assign vs = vs_pipe_q[SYNC_DLY-1];
        end
    endgenerate
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed bench: full-size timing plus small-geometry frame checks
module tb_vga_timing_gen;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    logic [9:0] m_x, m_y;
    logic       m_blank, m_hs, m_vs, m_vbs, m_fend;
    logic [7:0] m_fc;
    logic [9:0] z_x, z_y;
    logic       z_blank, z_hs, z_vs, z_vbs, z_fend;
    logic [7:0] z_fc;
    logic [9:0] t_x, t_y;
    logic       t_blank, t_hs, t_vs, t_vbs, t_fend;
    logic [7:0] t_fc;

    vga_timing_gen dut (
        .vga_clk(clk), .reset_n(reset_n), .DrawX(m_x), .DrawY(m_y), .blank(m_blank),
        .hs(m_hs), .vs(m_vs), .vblank_start(m_vbs), .frame_end(m_fend), .frame_count(m_fc)
    );

    // 16x12 geometry: hsync hc 10..12, vsync vc 8..9, 192 cycles per frame
    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2), .SYNC_DLY(0)
    ) dut_d0 (
        .vga_clk(clk), .reset_n(reset_n), .DrawX(z_x), .DrawY(z_y), .blank(z_blank),
        .hs(z_hs), .vs(z_vs), .vblank_start(z_vbs), .frame_end(z_fend), .frame_count(z_fc)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2), .SYNC_DLY(3)
    ) dut_d3 (
        .vga_clk(clk), .reset_n(reset_n), .DrawX(t_x), .DrawY(t_y), .blank(t_blank),
        .hs(t_hs), .vs(t_vs), .vblank_start(t_vbs), .frame_end(t_fend), .frame_count(t_fc)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic release_reset();
        reset_n = 1'b1;
        n = 0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (m_x !== 10'd0 || m_y !== 10'd0) begin bad++; $display("FAIL reset_pos x=%0d y=%0d want 0,0", m_x, m_y); end
        total++; if (m_blank !== 1'b1) begin bad++; $display("FAIL reset_blank got=%b want=1", m_blank); end
        total++; if (m_hs !== 1'b1 || m_vs !== 1'b1) begin bad++; $display("FAIL reset_sync hs=%b vs=%b want 1,1", m_hs, m_vs); end
        total++; if (m_vbs !== 1'b0 || m_fend !== 1'b0) begin bad++; $display("FAIL reset_pulses vbs=%b fend=%b want 0,0", m_vbs, m_fend); end
        total++; if (m_fc !== 8'd0) begin bad++; $display("FAIL reset_fc got=%0d want=0", m_fc); end
        total++; if (t_hs !== 1'b1 || t_vs !== 1'b1 || z_hs !== 1'b1) begin bad++; $display("FAIL reset_small_sync t_hs=%b t_vs=%b z_hs=%b want 1", t_hs, t_vs, z_hs); end
    endtask

    // Expects to be entered right after reset release (n == 0); covers two full lines
    task automatic test_line(input string tag);
        int pos_err = 0, blank_hi = 0, blank_lo_first = -1;
        int hs_lo = 0, hs_first = -1, hs_last = -1, vs_lo = 0, pulse_err = 0;
        for (int c = 0; c < 1600; c++) begin
            if (c != 0) tick();
            if (m_x !== 10'(c % 800) || m_y !== 10'(c / 800)) pos_err++;
            if (m_blank === 1'b1) blank_hi++;
            else if (blank_lo_first < 0) blank_lo_first = c;
            if (c < 800 && m_hs === 1'b0) begin
                hs_lo++;
                if (hs_first < 0) hs_first = c;
                hs_last = c;
            end
            if (m_vs !== 1'b1) vs_lo++;
            if (m_vbs !== 1'b0 || m_fend !== 1'b0) pulse_err++;
        end
        total++; if (pos_err != 0) begin bad++; $display("FAIL %s_pos errors=%0d want 0", tag, pos_err); end
        total++; if (blank_hi != 1280) begin bad++; $display("FAIL %s_blank_cnt got=%0d want=1280", tag, blank_hi); end
        total++; if (blank_lo_first != 640) begin bad++; $display("FAIL %s_blank_first_lo got=%0d want=640", tag, blank_lo_first); end
        total++; if (hs_lo != 96) begin bad++; $display("FAIL %s_hs_width got=%0d want=96", tag, hs_lo); end
        total++; if (hs_first != 657 || hs_last != 752) begin bad++; $display("FAIL %s_hs_window got=%0d..%0d want=657..752", tag, hs_first, hs_last); end
        total++; if (vs_lo != 0) begin bad++; $display("FAIL %s_vs_idle low_cycles=%0d want 0", tag, vs_lo); end
        total++; if (pulse_err != 0) begin bad++; $display("FAIL %s_no_pulses errors=%0d want 0", tag, pulse_err); end
    endtask

    task automatic test_mid_reset();
        while (n < 2300) tick();
        total++; if (m_x !== 10'd700 || m_y !== 10'd2 || m_hs !== 1'b0) begin bad++; $display("FAIL mid_pre x=%0d y=%0d hs=%b want 700,2,0", m_x, m_y, m_hs); end
        #2 reset_n = 1'b0;
        #1;
        total++; if (m_x !== 10'd0 || m_y !== 10'd0) begin bad++; $display("FAIL mid_async_pos x=%0d y=%0d want 0,0", m_x, m_y); end
        total++; if (m_hs !== 1'b1 || m_vs !== 1'b1 || m_blank !== 1'b1) begin bad++; $display("FAIL mid_async_out hs=%b vs=%b blank=%b want 1,1,1", m_hs, m_vs, m_blank); end
        repeat (2) @(posedge clk);
        #1;
        release_reset();
        test_line("after_reset");
    endtask

    task automatic test_small_frames();
        int stop = n + 576;
        int pos_err = 0, fc_err = 0, blank_err = 0, sync0_err = 0, sync3_err = 0;
        int fend_cnt = 0, vbs_cnt = 0, fend_err = 0, vbs_err = 0, blank_late = 0, t_hs_lo = 0;
        int hc, vc, dhc, dvc;
        while (n < stop) begin
            tick();
            hc  = n % 16;
            vc  = (n / 16) % 12;
            dhc = (n - 3) % 16;
            dvc = ((n - 3) / 16) % 12;
            if (z_x !== 10'(hc) || z_y !== 10'(vc) || t_x !== 10'(hc) || t_y !== 10'(vc)) pos_err++;
            if (z_fc !== 8'(n / 192) || t_fc !== 8'(n / 192)) fc_err++;
            if (z_blank !== ((hc < 8) && (vc < 6))) blank_err++;
            if (z_blank === 1'b1 && vc >= 6) blank_late++;
            if (z_hs !== !(hc >= 10 && hc <= 12) || z_vs !== !(vc >= 8 && vc <= 9)) sync0_err++;
            if (t_hs !== !(dhc >= 10 && dhc <= 12) || t_vs !== !(dvc >= 8 && dvc <= 9)) sync3_err++;
            if (t_hs === 1'b0) t_hs_lo++;
            if (z_fend === 1'b1) fend_cnt++;
            if (z_fend !== (n % 192 == 191)) fend_err++;
            if (z_vbs === 1'b1) vbs_cnt++;
            if (z_vbs !== (hc == 0 && vc == 6)) vbs_err++;
        end
        total++; if (pos_err != 0) begin bad++; $display("FAIL small_pos errors=%0d want 0", pos_err); end
        total++; if (fc_err != 0) begin bad++; $display("FAIL small_frame_count errors=%0d want 0", fc_err); end
        total++; if (blank_err != 0 || blank_late != 0) begin bad++; $display("FAIL small_blank errors=%0d late=%0d want 0,0", blank_err, blank_late); end
        total++; if (sync0_err != 0) begin bad++; $display("FAIL small_sync_dly0 errors=%0d want 0", sync0_err); end
        total++; if (sync3_err != 0) begin bad++; $display("FAIL small_sync_dly3 errors=%0d want 0", sync3_err); end
        total++; if (t_hs_lo != 108) begin bad++; $display("FAIL small_hs_low_cnt got=%0d want=108", t_hs_lo); end
        total++; if (fend_cnt != 3 || fend_err != 0) begin bad++; $display("FAIL small_frame_end cnt=%0d err=%0d want 3,0", fend_cnt, fend_err); end
        total++; if (vbs_cnt != 3 || vbs_err != 0) begin bad++; $display("FAIL small_vblank_start cnt=%0d err=%0d want 3,0", vbs_cnt, vbs_err); end
    endtask

    task automatic test_fc_wrap();
        while (n < 256 * 192 - 1) tick();
        total++; if (z_fc !== 8'd255 || z_fend !== 1'b1) begin bad++; $display("FAIL wrap_pre fc=%0d fend=%b want 255,1", z_fc, z_fend); end
        total++; if (z_x !== 10'd15 || z_y !== 10'd11) begin bad++; $display("FAIL wrap_pre_pos x=%0d y=%0d want 15,11", z_x, z_y); end
        tick();
        total++; if (z_fc !== 8'd0 || t_fc !== 8'd0) begin bad++; $display("FAIL wrap_fc z=%0d t=%0d want 0,0", z_fc, t_fc); end
        total++; if (z_x !== 10'd0 || z_y !== 10'd0 || z_blank !== 1'b1) begin bad++; $display("FAIL wrap_pos x=%0d y=%0d blank=%b want 0,0,1", z_x, z_y, z_blank); end
        total++; if (z_hs !== 1'b1 || z_vs !== 1'b1 || z_fend !== 1'b0 || z_vbs !== 1'b0) begin bad++; $display("FAIL wrap_glitch hs=%b vs=%b fend=%b vbs=%b want 1,1,0,0", z_hs, z_vs, z_fend, z_vbs); end
        total++; if (m_x !== 10'd352 || m_y !== 10'd61 || m_fc !== 8'd0) begin bad++; $display("FAIL wrap_main x=%0d y=%0d fc=%0d want 352,61,0", m_x, m_y, m_fc); end
    endtask

    initial begin
        n = 0;
        test_reset();
        release_reset();
        test_line("line");
        test_mid_reset();
        test_small_frames();
        test_fc_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
